// File: rtl/abh_abl_alu_pkg.sv
// rtl/abh_abl_alu_pkg.sv - shared encodings for the address unit, ALU, carry-in and flag control
package abh_abl_alu_pkg;

    // ADL base source, abl_op[3:2]
    typedef enum logic [1:0] {
        ABL_BASE_ADL  = 2'b00,
        ABL_BASE_PCL  = 2'b01,
        ABL_BASE_AHL  = 2'b10,
        ABL_BASE_ZERO = 2'b11
    } abl_base_e;

    // ADL offset source, abl_op[1:0]
    typedef enum logic [1:0] {
        ABL_OFS_ZERO = 2'b00,
        ABL_OFS_DB   = 2'b01,
        ABL_OFS_R    = 2'b10,
        ABL_OFS_COND = 2'b11
    } abl_ofs_e;

    // ADH source, abh_op[3:1]
    typedef enum logic [2:0] {
        ABH_SRC_ADH     = 3'b000,
        ABH_SRC_PCH     = 3'b001,
        ABH_SRC_DB      = 3'b010,
        ABH_SRC_ZERO    = 3'b011,
        ABH_SRC_ONE     = 3'b100,
        ABH_SRC_FF      = 3'b101,
        ABH_SRC_PCH_DEC = 3'b110,
        ABH_SRC_ADH_DEC = 3'b111
    } abh_src_e;

    // ALU operand A, alu_op[1:0]
    typedef enum logic [1:0] {
        ALU_A_R    = 2'b00,
        ALU_A_DB   = 2'b01,
        ALU_A_M    = 2'b10,
        ALU_A_ZERO = 2'b11
    } alu_a_e;

    // ALU operand B, alu_op[3:2]
    typedef enum logic [1:0] {
        ALU_B_DB   = 2'b00,
        ALU_B_M    = 2'b01,
        ALU_B_ZERO = 2'b10,
        ALU_B_FF   = 2'b11
    } alu_b_e;

    // ALU function, alu_op[6:4]
    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_AND  = 3'b010,
        ALU_OR   = 3'b011,
        ALU_EOR  = 3'b100,
        ALU_ROL  = 3'b101,
        ALU_ROR  = 3'b110,
        ALU_PASS = 3'b111
    } alu_fn_e;

    // Carry-in select, flag_op[9:8]
    typedef enum logic [1:0] {
        CI_ZERO     = 2'b00,
        CI_ONE      = 2'b01,
        CI_C        = 2'b10,
        CI_ZERO_ALT = 2'b11
    } ci_sel_e;

    // Special flag operation, flag_op[7:4]
    typedef enum logic [3:0] {
        FSP_NONE = 4'h0,
        FSP_CLC  = 4'h1,
        FSP_SEC  = 4'h2,
        FSP_CLI  = 4'h3,
        FSP_SEI  = 4'h4,
        FSP_CLV  = 4'h5,
        FSP_CLD  = 4'h6,
        FSP_SED  = 4'h7,
        FSP_LDP  = 4'h8,
        FSP_BIT  = 4'h9,
        FSP_IRQ  = 4'hA
    } flag_sp_e;

    // Status register bit positions
    localparam int P_C = 0;
    localparam int P_Z = 1;
    localparam int P_I = 2;
    localparam int P_D = 3;
    localparam int P_B = 4;
    localparam int P_U = 5;
    localparam int P_V = 6;
    localparam int P_N = 7;

endpackage

// File: rtl/addr_unit.sv
// rtl/addr_unit.sv - ADL/ADH address adders, AHL latch and program counter
module addr_unit
    import abh_abl_alu_pkg::*;
(
    input  logic        clk,
    input  logic        RST_N,
    input  logic [11:0] ab_op,
    input  logic [7:0]  DB,
    input  logic [7:0]  R,
    input  logic        cond,
    output logic [15:0] AD,
    output logic [15:0] PC
);

    logic [7:0]  adl_q, adh_q, ahl_q;
    logic [15:0] pc_q;
    logic [7:0]  adl_d, adh_d;
    logic [15:0] pc_d;
    logic [7:0]  abl_base, abl_ofs, abh_src;
    logic        abl_co;

    // Low address byte: base + offset + carry-in; carry feeds the high byte
    always_comb begin
        abl_base = 8'h00;
        case (abl_base_e'(ab_op[4:3]))
            ABL_BASE_ADL:  abl_base = adl_q;
            ABL_BASE_PCL:  abl_base = pc_q[7:0];
            ABL_BASE_AHL:  abl_base = ahl_q;
            ABL_BASE_ZERO: abl_base = 8'h00;
            default:       abl_base = 8'h00;
        endcase
        abl_ofs = 8'h00;
        case (abl_ofs_e'(ab_op[2:1]))
            ABL_OFS_ZERO: abl_ofs = 8'h00;
            ABL_OFS_DB:   abl_ofs = DB;
            ABL_OFS_R:    abl_ofs = R;
            ABL_OFS_COND: abl_ofs = cond ? DB : 8'h00;
            default:      abl_ofs = 8'h00;
        endcase
        {abl_co, adl_d} = {1'b0, abl_base} + {1'b0, abl_ofs} + {8'h00, ab_op[0]};
    end

    // High address byte: selected source plus optional low-byte carry
    always_comb begin
        abh_src = 8'h00;
        case (abh_src_e'(ab_op[8:6]))
            ABH_SRC_ADH:     abh_src = adh_q;
            ABH_SRC_PCH:     abh_src = pc_q[15:8];
            ABH_SRC_DB:      abh_src = DB;
            ABH_SRC_ZERO:    abh_src = 8'h00;
            ABH_SRC_ONE:     abh_src = 8'h01;
            ABH_SRC_FF:      abh_src = 8'hFF;
            ABH_SRC_PCH_DEC: abh_src = pc_q[15:8] + 8'hFF;
            ABH_SRC_ADH_DEC: abh_src = adh_q + 8'hFF;
            default:         abh_src = 8'h00;
        endcase
        adh_d = abh_src + {7'h00, ab_op[5] & abl_co};
    end

    assign AD = {adh_d, adl_d};

    // Next PC: optionally loaded from the live address, then incremented
    always_comb begin
        pc_d = (ab_op[10] ? AD : pc_q) + {15'h0000, ab_op[11]};
    end

    // Address, AHL and PC registers; reset overrides every load
    always_ff @(posedge clk) begin
        if (!RST_N) begin
            adl_q <= 8'h00;
            adh_q <= 8'h00;
            ahl_q <= 8'h00;
            pc_q  <= 16'h0000;
        end else begin
            adl_q <= adl_d;
            adh_q <= adh_d;
            if (ab_op[9]) begin
                ahl_q <= DB;
            end
            pc_q  <= pc_d;
        end
    end

    assign PC = pc_q;

endmodule

// File: rtl/abh_abl_alu.sv
// rtl/abh_abl_alu.sv - address unit, 8-bit ALU, status flags and branch condition (option ABH_ABL_ALU_BCD_EN)
module abh_abl_alu
    import abh_abl_alu_pkg::*;
(
    input  logic        clk,
    input  logic        RST_N,
    input  logic [11:0] ab_op,
    input  logic [7:0]  DB,
    input  logic [7:0]  R,
    input  logic [6:0]  alu_op,
    input  logic [9:0]  flag_op,
    input  logic        sync,
    input  logic        ld_m,
    input  logic        adj_m,
    input  logic        B,
    output logic [15:0] AD,
    output logic [15:0] PC,
    output logic [7:0]  P,
    output logic [7:0]  OUT,
    output logic        CO,
    output logic        cond
);

    logic [7:0] m_q;
    logic [2:0] ir_q;
    logic       bra_q;
    logic       n_q, v_q, d_q, i_q, z_q, c_q;
    logic       n_d, v_d, d_d, i_d, z_d, c_d;

    logic [7:0] alu_a, alu_b, b_eff, bin_out;
    logic [8:0] sum9;
    logic       ci, bin_co, alu_v, cond_flag;
    alu_fn_e    alu_fn;

    // flag_op[3] carries no function
    logic unused_fop3;
    assign unused_fop3 = flag_op[3];

    addr_unit u_addr (
        .clk   (clk),
        .RST_N (RST_N),
        .ab_op (ab_op),
        .DB    (DB),
        .R     (R),
        .cond  (cond),
        .AD    (AD),
        .PC    (PC)
    );

    assign alu_fn = alu_fn_e'(alu_op[6:4]);

    // Operand and carry-in selection
    always_comb begin
        alu_a = 8'h00;
        case (alu_a_e'(alu_op[1:0]))
            ALU_A_R:    alu_a = R;
            ALU_A_DB:   alu_a = DB;
            ALU_A_M:    alu_a = m_q;
            ALU_A_ZERO: alu_a = 8'h00;
            default:    alu_a = 8'h00;
        endcase
        alu_b = 8'h00;
        case (alu_b_e'(alu_op[3:2]))
            ALU_B_DB:   alu_b = DB;
            ALU_B_M:    alu_b = m_q;
            ALU_B_ZERO: alu_b = 8'h00;
            ALU_B_FF:   alu_b = 8'hFF;
            default:    alu_b = 8'h00;
        endcase
        ci = 1'b0;
        case (ci_sel_e'(flag_op[9:8]))
            CI_ZERO:     ci = 1'b0;
            CI_ONE:      ci = 1'b1;
            CI_C:        ci = c_q;
            CI_ZERO_ALT: ci = 1'b0;
            default:     ci = 1'b0;
        endcase
    end

    // Binary ALU; subtraction is addition of the complemented operand
    always_comb begin
        b_eff = (alu_fn == ALU_SUB) ? ~alu_b : alu_b;
        sum9  = {1'b0, alu_a} + {1'b0, b_eff} + {8'h00, ci};
        alu_v = (alu_a[7] == b_eff[7]) && (sum9[7] != alu_a[7]);
        bin_out = 8'h00;
        bin_co  = 1'b0;
        case (alu_fn)
            ALU_ADD, ALU_SUB: begin
                bin_out = sum9[7:0];
                bin_co  = sum9[8];
            end
            ALU_AND:  bin_out = alu_a & alu_b;
            ALU_OR:   bin_out = alu_a | alu_b;
            ALU_EOR:  bin_out = alu_a ^ alu_b;
            ALU_ROL: begin
                bin_out = {alu_a[6:0], ci};
                bin_co  = alu_a[7];
            end
            ALU_ROR: begin
                bin_out = {ci, alu_a[7:1]};
                bin_co  = alu_a[0];
            end
            ALU_PASS: bin_out = alu_a;
            default:  bin_out = alu_a;
        endcase
    end

`ifdef ABH_ABL_ALU_BCD_EN
    logic       dec_en, lo_c, hi_c;
    logic [4:0] lo_s, hi_s;
    logic [3:0] lo_r, hi_r;

    // Per-nibble decimal correction of add/sub when D and adj_m are both set
    always_comb begin
        dec_en = d_q & adj_m & ((alu_fn == ALU_ADD) || (alu_fn == ALU_SUB));
        lo_s = {1'b0, alu_a[3:0]} + {1'b0, b_eff[3:0]} + {4'h0, ci};
        if (alu_fn == ALU_SUB) begin
            lo_c = lo_s[4];
            lo_r = lo_c ? lo_s[3:0] : lo_s[3:0] - 4'd6;
        end else begin
            lo_c = lo_s > 5'd9;
            lo_r = lo_c ? lo_s[3:0] + 4'd6 : lo_s[3:0];
        end
        hi_s = {1'b0, alu_a[7:4]} + {1'b0, b_eff[7:4]} + {4'h0, lo_c};
        if (alu_fn == ALU_SUB) begin
            hi_c = hi_s[4];
            hi_r = hi_c ? hi_s[3:0] : hi_s[3:0] - 4'd6;
        end else begin
            hi_c = hi_s > 5'd9;
            hi_r = hi_c ? hi_s[3:0] + 4'd6 : hi_s[3:0];
        end
        OUT = dec_en ? {hi_r, lo_r} : bin_out;
        CO  = dec_en ? hi_c : bin_co;
    end
`else
    logic unused_adj_m;
    assign unused_adj_m = adj_m;
    assign OUT = bin_out;
    assign CO  = bin_co;
`endif

    // Next flag values: ALU updates first, special operations override
    always_comb begin
        n_d = n_q;
        v_d = v_q;
        d_d = d_q;
        i_d = i_q;
        z_d = z_q;
        c_d = c_q;
        if (flag_op[0]) begin
            n_d = OUT[7];
            z_d = (OUT == 8'h00);
        end
        if (flag_op[1]) begin
            c_d = CO;
        end
        if (flag_op[2]) begin
            v_d = alu_v;
        end
        case (flag_sp_e'(flag_op[7:4]))
            FSP_CLC: c_d = 1'b0;
            FSP_SEC: c_d = 1'b1;
            FSP_CLI: i_d = 1'b0;
            FSP_SEI: i_d = 1'b1;
            FSP_CLV: v_d = 1'b0;
            FSP_CLD: d_d = 1'b0;
            FSP_SED: d_d = 1'b1;
            FSP_LDP: begin
                n_d = DB[P_N];
                v_d = DB[P_V];
                d_d = DB[P_D];
                i_d = DB[P_I];
                z_d = DB[P_Z];
                c_d = DB[P_C];
            end
            FSP_BIT: begin
                n_d = DB[7];
                v_d = DB[6];
                z_d = ((R & DB) == 8'h00);
            end
            FSP_IRQ: begin
                i_d = 1'b1;
                d_d = 1'b0;
            end
            default: ;
        endcase
    end

    // Flag, M, IR and branch-latch registers
    always_ff @(posedge clk) begin
        if (!RST_N) begin
            n_q   <= 1'b0;
            v_q   <= 1'b0;
            d_q   <= 1'b0;
            i_q   <= 1'b1;
            z_q   <= 1'b0;
            c_q   <= 1'b0;
            m_q   <= 8'h00;
            ir_q  <= 3'b000;
            bra_q <= 1'b0;
        end else begin
            n_q <= n_d;
            v_q <= v_d;
            d_q <= d_d;
            i_q <= i_d;
            z_q <= z_d;
            c_q <= c_d;
            if (ld_m) begin
                m_q <= DB;
            end
            if (sync) begin
                ir_q  <= DB[7:5];
                bra_q <= (DB == 8'h80);
            end
        end
    end

    // Branch condition: unconditional branch, else selected flag against IR[5]
    always_comb begin
        case (ir_q[2:1])
            2'd0:    cond_flag = n_q;
            2'd1:    cond_flag = v_q;
            2'd2:    cond_flag = c_q;
            default: cond_flag = z_q;
        endcase
        cond = bra_q | (cond_flag == ir_q[0]);
    end

    // Status byte assembly
    always_comb begin
        P      = 8'h00;
        P[P_N] = n_q;
        P[P_V] = v_q;
        P[P_U] = 1'b1;
        P[P_B] = B;
        P[P_D] = d_q;
        P[P_I] = i_q;
        P[P_Z] = z_q;
        P[P_C] = c_q;
    end

endmodule

// File: tb/tb_abh_abl_alu.sv
// tb/tb_abh_abl_alu.sv - directed scoreboard bench for abh_abl_alu
module tb_abh_abl_alu;

    logic        clk = 1'b0;
    logic        RST_N;
    logic [11:0] ab_op;
    logic [7:0]  DB, R;
    logic [6:0]  alu_op;
    logic [9:0]  flag_op;
    logic        sync, ld_m, adj_m, B;
    logic [15:0] AD, PC;
    logic [7:0]  P, OUT;
    logic        CO, cond;

    typedef struct {
        string       tag;
        logic [15:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    abh_abl_alu dut (
        .clk     (clk),
        .RST_N   (RST_N),
        .ab_op   (ab_op),
        .DB      (DB),
        .R       (R),
        .alu_op  (alu_op),
        .flag_op (flag_op),
        .sync    (sync),
        .ld_m    (ld_m),
        .adj_m   (adj_m),
        .B       (B),
        .AD      (AD),
        .PC      (PC),
        .P       (P),
        .OUT     (OUT),
        .CO      (CO),
        .cond    (cond)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] mk_ab(input logic inc, input logic ld, input logic ahl,
                                          input logic [3:0] abh, input logic [3:0] abl,
                                          input logic ci);
        return {inc, ld, ahl, abh, abl, ci};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_v(input string tag, input logic [15:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check(input logic [15:0] obs);
        exp_t e;
        n_assert++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty observed=%h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    initial begin
        RST_N = 1'b0; ab_op = '0; DB = '0; R = '0; alu_op = '0; flag_op = '0;
        sync = 1'b0; ld_m = 1'b0; adj_m = 1'b0; B = 1'b0;

        // reset state
        tick();
        expect_v("reset_P", 16'h0024);     check({8'h00, P});
        expect_v("reset_PC", 16'h0000);    check(PC);
        expect_v("reset_AD", 16'h0000);    check(AD);
        expect_v("reset_cond", 16'h0001);  check({15'h0, cond});
        RST_N = 1'b1;

        // signed overflow on add
        R = 8'h7F; DB = 8'h01; alu_op = 7'h00; flag_op = 10'h007;
        expect_v("add_OUT", 16'h0080); expect_v("add_CO", 16'h0000);
        #1; check({8'h00, OUT}); check({15'h0, CO});
        expect_v("add_P", 16'h00E4);
        tick(); check({8'h00, P});
        flag_op = '0;

        // subtract with borrow
        R = 8'h10; DB = 8'h20; alu_op = 7'h10; flag_op = 10'h107;
        expect_v("sub_OUT", 16'h00F0); expect_v("sub_CO", 16'h0000);
        #1; check({8'h00, OUT}); check({15'h0, CO});
        expect_v("sub_P", 16'h00A4);
        tick(); check({8'h00, P});
        flag_op = '0;

        // logic ops and rotate left
        R = 8'h3C; DB = 8'h0F; alu_op = 7'h20;
        expect_v("and_OUT", 16'h000C); #1; check({8'h00, OUT});
        alu_op = 7'h30;
        expect_v("or_OUT", 16'h003F);  #1; check({8'h00, OUT});
        alu_op = 7'h40;
        expect_v("eor_OUT", 16'h0033); #1; check({8'h00, OUT});
        R = 8'h81; alu_op = 7'h50; flag_op = 10'h100;
        expect_v("rol_OUT", 16'h0003); expect_v("rol_CO", 16'h0001);
        #1; check({8'h00, OUT}); check({15'h0, CO});
        flag_op = '0;

        // M load, pass M, and zero + FF operands
        DB = 8'h5A; ld_m = 1'b1; tick(); ld_m = 1'b0; DB = 8'h00;
        alu_op = 7'h72;
        expect_v("pass_M", 16'h005A); #1; check({8'h00, OUT});
        alu_op = 7'h0F;
        expect_v("zero_plus_FF", 16'h00FF); #1; check({8'h00, OUT});

        // special SEC beats CO-driven C update in the same cycle
        R = 8'h00; DB = 8'h00; alu_op = 7'h00; flag_op = 10'h023;
        expect_v("sec_prio_P", 16'h0027);
        tick(); check({8'h00, P});
        flag_op = '0;

        // rotate right through C
        R = 8'h02; alu_op = 7'h60; flag_op = 10'h200;
        expect_v("ror_OUT", 16'h0081); expect_v("ror_CO", 16'h0000);
        #1; check({8'h00, OUT}); check({15'h0, CO});
        flag_op = '0;

        // P <= DB, B visible on bit 4
        DB = 8'hFF; flag_op = 10'h080;
        expect_v("ldp_P", 16'h00EF);
        tick(); flag_op = '0; check({8'h00, P});
        B = 1'b1;
        expect_v("B_bit", 16'h00FF); #1; check({8'h00, P});
        B = 1'b0;

        // clear ops and the interrupt-entry op
        flag_op = 10'h010; expect_v("clc_P", 16'h00EE); tick(); check({8'h00, P});
        flag_op = 10'h050; expect_v("clv_P", 16'h00AE); tick(); check({8'h00, P});
        flag_op = 10'h030; expect_v("cli_P", 16'h00AA); tick(); check({8'h00, P});
        flag_op = 10'h0A0; expect_v("irq_P", 16'h00A6); tick(); check({8'h00, P});

        // BIT
        R = 8'h40; DB = 8'hC0; flag_op = 10'h090;
        expect_v("bit_P", 16'h00E4); tick(); check({8'h00, P});
        flag_op = '0;

        // build PC = 12FF through the address path
        DB = 8'h12; ab_op = mk_ab(0, 0, 0, 4'b0100, 4'b1101, 0);
        expect_v("AD_1212", 16'h1212); #1; check(AD);
        tick();
        DB = 8'hFF; ab_op = mk_ab(0, 1, 0, 4'b0000, 4'b1101, 0);
        expect_v("AD_12FF", 16'h12FF); #1; check(AD);
        expect_v("PC_12FF", 16'h12FF); tick(); check(PC);

        // page crossing PCL + DB, carry into PCH
        DB = 8'h01; ab_op = mk_ab(0, 0, 0, 4'b0011, 4'b0101, 0);
        expect_v("AD_page_cross", 16'h1300); #1; check(AD);
        ab_op = mk_ab(1, 1, 0, 4'b0011, 4'b0101, 0);
        expect_v("PC_ld_inc", 16'h1301); tick(); check(PC);

        // AHL base with carry-in, FF high byte
        DB = 8'h34; ab_op = mk_ab(0, 0, 1, 4'b0000, 4'b0000, 0); tick();
        DB = 8'h00; ab_op = mk_ab(0, 0, 0, 4'b1010, 4'b1000, 1);
        expect_v("AD_FF35", 16'hFF35); #1; check(AD);

        // PCH - 1 high byte, R offset
        R = 8'h80; ab_op = mk_ab(0, 0, 0, 4'b1100, 4'b1110, 0);
        expect_v("AD_pch_dec", 16'h1280); #1; check(AD);

        // 01 high byte plus carry from FF + 1
        DB = 8'hFF; ab_op = mk_ab(0, 0, 0, 4'b1001, 4'b1101, 1);
        expect_v("AD_0200", 16'h0200); #1; check(AD);

        // PC wraps FFFF -> 0000
        DB = 8'hFF; ab_op = mk_ab(1, 1, 0, 4'b0100, 4'b1101, 0);
        expect_v("PC_wrap", 16'h0000); tick(); check(PC);
        ab_op = '0;

        // set Z, then branch conditions from sync
        R = 8'h00; DB = 8'h00; alu_op = 7'h00; flag_op = 10'h001; tick(); flag_op = '0;
        sync = 1'b1; DB = 8'hF0;
        expect_v("cond_F0", 16'h0001); tick(); check({15'h0, cond});
        DB = 8'hD0;
        expect_v("cond_D0", 16'h0000); tick(); check({15'h0, cond});
        DB = 8'h80;
        expect_v("cond_80", 16'h0001); tick(); check({15'h0, cond});
        sync = 1'b0;
        DB = 8'h2B; ab_op = mk_ab(0, 0, 0, 4'b0110, 4'b1111, 0);
        expect_v("AD_cond_ofs", 16'h002B); #1; check(AD);
        ab_op = '0;

        // decimal mode add and subtract
        flag_op = 10'h070; tick(); flag_op = '0;
        adj_m = 1'b1; R = 8'h09; DB = 8'h01; alu_op = 7'h00;
`ifdef ABH_ABL_ALU_BCD_EN
        expect_v("bcd_add", 16'h0010);
`else
        expect_v("bcd_add", 16'h000A);
`endif
        expect_v("bcd_add_CO", 16'h0000);
        #1; check({8'h00, OUT}); check({15'h0, CO});
        R = 8'h10; DB = 8'h01; alu_op = 7'h10; flag_op = 10'h100;
`ifdef ABH_ABL_ALU_BCD_EN
        expect_v("bcd_sub", 16'h0009);
`else
        expect_v("bcd_sub", 16'h000F);
`endif
        expect_v("bcd_sub_CO", 16'h0001);
        #1; check({8'h00, OUT}); check({15'h0, CO});
        adj_m = 1'b0; flag_op = '0;

        // reset beats concurrent loads
        RST_N = 1'b0; DB = 8'hFF; ld_m = 1'b1; flag_op = 10'h080;
        ab_op = mk_ab(1, 1, 1, 4'b0100, 4'b1101, 0);
        tick();
        ab_op = '0; ld_m = 1'b0; flag_op = '0;
        expect_v("rst2_P", 16'h0024);  check({8'h00, P});
        expect_v("rst2_PC", 16'h0000); check(PC);
        #1;
        expect_v("rst2_AD", 16'h0000); check(AD);
        RST_N = 1'b1; DB = 8'h00; alu_op = 7'h72;
        expect_v("rst2_M", 16'h0000); #1; check({8'h00, OUT});

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
